// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, split unaligned accesses over two
// word cycles, sign/zero-extended load results and a one-cycle response pulse.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [2:0]  mem_rd_en,
    output logic [2:0]  mem_wr_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_data
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t      state, state_next;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [31:0] word0;

    logic        req_illegal;
    logic [7:0]  ones;
    logic [7:0]  lane;
    logic        split;
    logic [31:0] w0, w1;
    logic [31:0] ld;
    logic [31:0] ld_ext;

    assign req_illegal = (req_load == req_store)
                      || (req_load  && (req_funct3 inside {3'b011, 3'b110, 3'b111}))
                      || (req_store && (req_funct3 > 3'b010));

    // Byte lanes across a two-word window: low nibble is ACC1, high nibble ACC2.
    always_comb begin
        ones = 8'h0F;
        if (funct3[1:0] == 2'b00)      ones = 8'h01;
        else if (funct3[1:0] == 2'b01) ones = 8'h03;
    end

    assign lane  = ones << off;
    assign split = (lane[7:4] != 4'b0000);

    assign w0 = (state == ACC2) ? word0 : mem_rdata;
    assign w1 = (state == ACC2) ? mem_rdata : '0;
    assign ld = 32'({w1, w0} >> {off, 3'b000});

    always_comb begin
        ld_ext = ld;
        case (funct3)
            3'b000:  ld_ext = {{24{ld[7]}}, ld[7:0]};
            3'b001:  ld_ext = {{16{ld[15]}}, ld[15:0]};
            3'b100:  ld_ext = {24'b0, ld[7:0]};
            3'b101:  ld_ext = {16'b0, ld[15:0]};
            default: ld_ext = ld;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_illegal ? RESP : ACC1;
            ACC1:    state_next = split ? ACC2 : RESP;
            ACC2:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 3'b000;
        mem_wr_en = 3'b000;
        mem_mask  = 4'b0000;
        if (state == ACC1 || state == ACC2) begin
            if (is_load) begin
                mem_rd_en = 3'b001;
            end else begin
                mem_wr_en = 3'b001;
                mem_mask  = (state == ACC1) ? lane[3:0] : lane[7:4];
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_load   <= 1'b0;
            funct3    <= '0;
            off       <= '0;
            wdata     <= '0;
            word0     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req_valid) begin
                    is_load  <= req_load;
                    funct3   <= req_funct3;
                    off      <= req_addr[1:0];
                    wdata    <= req_wdata;
                    rsp_err  <= req_illegal;
                    rsp_data <= '0;
                    if (!req_illegal) begin
                        mem_addr <= {2'b00, req_addr[31:2]};
                        if (req_store)
                            mem_wdata <= 32'({32'b0, req_wdata} << {req_addr[1:0], 3'b000});
                    end
                end
                ACC1: begin
                    word0 <= mem_rdata;
                    if (split) begin
                        mem_addr <= {2'b00, mem_addr[29:0] + 30'd1};
                        if (!is_load)
                            mem_wdata <= 32'(({32'b0, wdata} << {off, 3'b000}) >> 32);
                    end else if (is_load) begin
                        rsp_data <= ld_ext;
                    end
                end
                ACC2: if (is_load) rsp_data <= ld_ext;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-masked word memory model
// that commits writes on the negedge of each access cycle.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic [2:0]  mem_rd_en, mem_wr_en;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_mask(mem_mask),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data)
    );

    assign mem_rdata = mem[mem_addr[3:0]];

    always @(negedge clk) begin
        if (mem_wr_en == 3'b001)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer a request in IDLE; returns one cycle after the accepting edge.
    task automatic offer(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    endtask

    // Accept cycle counts as cycle 1, so rsp_valid in cycle N is N-1 edges later.
    task automatic wait_rsp(input string tag, input int start, input int exp_edges);
        int n = start;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        chk(tag, n, exp_edges);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        step(); step();
        rst = 1'b0;

        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_enables", {25'b0, mem_rd_en, mem_mask}, 32'h0);

        // SW aligned
        offer(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_acc1_addr", mem_addr, 32'd4);
        chk("sw_acc1_mask", {28'b0, mem_mask}, 32'hF);
        chk("sw_acc1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_acc1_wr_en", {29'b0, mem_wr_en}, 32'd1);
        chk("sw_acc1_rd_en", {29'b0, mem_rd_en}, 32'd0);
        chk("sw_acc1_ready", {31'b0, req_ready}, 32'd0);
        wait_rsp("sw_latency", 1, 2);
        chk("sw_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("sw_rsp_data", rsp_data, 32'h0);
        chk("sw_resp_wr_en", {28'b0, mem_mask}, 32'h0);
        chk("sw_resp_addr_hold", mem_addr, 32'd4);
        step();
        chk("sw_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("sw_pulse_len", {31'b0, rsp_valid}, 32'd0);
        chk("sw_mem4", mem[4], 32'hDEADBEEF);

        // Byte/half loads, sign and zero extension
        mem[4] = 32'h80112233;
        offer(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_rd_en", {29'b0, mem_rd_en}, 32'd1);
        chk("lb_mask", {28'b0, mem_mask}, 32'h0);
        wait_rsp("lb_latency", 1, 2);
        chk("lb_data", rsp_data, 32'hFFFFFF80);
        step();
        offer(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        wait_rsp("lbu_latency", 1, 2);
        chk("lbu_data", rsp_data, 32'h00000080);
        step();
        offer(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        wait_rsp("lh_latency", 1, 2);
        chk("lh_data", rsp_data, 32'hFFFF8011);
        step();
        offer(1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
        wait_rsp("lhu_latency", 1, 2);
        chk("lhu_data", rsp_data, 32'h00008011);
        step();

        // Split SW
        mem[3] = '0; mem[4] = '0;
        offer(1'b0, 1'b1, 3'b010, 32'h0D, 32'h11223344);
        chk("ssw_acc1_addr", mem_addr, 32'd3);
        chk("ssw_acc1_mask", {28'b0, mem_mask}, 32'hE);
        chk("ssw_acc1_wdata", mem_wdata, 32'h22334400);
        step();
        chk("ssw_acc2_addr", mem_addr, 32'd4);
        chk("ssw_acc2_mask", {28'b0, mem_mask}, 32'h1);
        chk("ssw_acc2_wdata", mem_wdata, 32'h00000011);
        wait_rsp("ssw_latency", 2, 3);
        chk("ssw_rsp_data", rsp_data, 32'h0);
        step();
        chk("ssw_mem3", mem[3], 32'h22334400);
        chk("ssw_mem4", mem[4], 32'h00000011);

        // Split LH
        mem[3] = 32'hAB000000; mem[4] = 32'h000000CD;
        offer(1'b1, 1'b0, 3'b001, 32'h0F, 32'h0);
        chk("slh_acc1_addr", mem_addr, 32'd3);
        step();
        chk("slh_acc2_addr", mem_addr, 32'd4);
        chk("slh_acc2_rd_en", {29'b0, mem_rd_en}, 32'd1);
        wait_rsp("slh_latency", 2, 3);
        chk("slh_data", rsp_data, 32'hFFFFCDAB);
        step();

        // Split LW wrapping the word index
        mem[15] = 32'h12340000; mem[0] = 32'h0000ABCD;
        offer(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        chk("wrap_acc1_addr", mem_addr, 32'h3FFFFFFF);
        step();
        chk("wrap_acc2_addr", mem_addr, 32'h0);
        wait_rsp("wrap_latency", 2, 3);
        chk("wrap_data", rsp_data, 32'hABCD1234);
        step();

        // Illegal requests
        offer(1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
        chk("ill_f3_enables", {25'b0, mem_rd_en, mem_mask}, 32'h0);
        chk("ill_f3_wr_en", {29'b0, mem_wr_en}, 32'd0);
        chk("ill_f3_addr_hold", mem_addr, 32'h0);
        wait_rsp("ill_f3_latency", 1, 1);
        chk("ill_f3_err", {31'b0, rsp_err}, 32'd1);
        chk("ill_f3_data", rsp_data, 32'h0);
        step();
        offer(1'b1, 1'b1, 3'b010, 32'h24, 32'h55555555);
        chk("ill_both_enables", {22'b0, mem_rd_en, mem_wr_en, mem_mask}, 32'h0);
        wait_rsp("ill_both_latency", 1, 1);
        chk("ill_both_err", {31'b0, rsp_err}, 32'd1);
        chk("ill_both_data", rsp_data, 32'h0);
        step();
        offer(1'b0, 1'b1, 3'b100, 32'h24, 32'h55555555);
        chk("ill_st_f3_wr_en", {29'b0, mem_wr_en}, 32'd0);
        wait_rsp("ill_st_f3_latency", 1, 1);
        chk("ill_st_f3_err", {31'b0, rsp_err}, 32'd1);
        step();
        chk("ill_after_ready", {31'b0, req_ready}, 32'd1);

        // Reset during ACC1 of a split SW
        mem[3] = '0; mem[4] = '0;
        offer(1'b0, 1'b1, 3'b010, 32'h0D, 32'hAABBCCDD);
        chk("abort_acc1_wr_en", {29'b0, mem_wr_en}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_wr_en", {29'b0, mem_wr_en}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_mem_wdata", mem_wdata, 32'h0);
        step();
        chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("abort_mem4", mem[4], 32'h0);

        // Recovery after abort
        mem[4] = 32'hCAFEF00D;
        offer(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        wait_rsp("rec_latency", 1, 2);
        chk("rec_data", rsp_data, 32'hCAFEF00D);
        chk("rec_err", {31'b0, rsp_err}, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  request offered this cycle.
REQ-004 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-005 req_load  input  1  request is a load.
REQ-006 req_store  input  1  request is a store.
REQ-007 req_funct3  input  3  LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-justified.
REQ-010 mem_addr  output  32  word index to data memory, {2'b00, byte_addr[31:2]}.
REQ-011 mem_mask  output  4  byte-lane write mask to data memory.
REQ-012 mem_rd_en  output  3  3'b001 during a load access, else 3'b000.
REQ-013 mem_wr_en  output  3  3'b001 during a store access, else 3'b000.
REQ-014 mem_wdata  output  32  lane-aligned store data.
REQ-015 mem_rdata  input  32  combinational read word from data memory.
REQ-016 rsp_valid  output  1  one-cycle pulse: transaction complete.
REQ-017 rsp_err  output  1  qualifies rsp_valid: illegal request.
REQ-018 rsp_data  output  32  extended load result; 0 for stores and errors.

Function
REQ-019 States IDLE, ACC1, ACC2, RESP; req_ready = 1 only in IDLE.
REQ-020 Accept in IDLE: register load/store flag, funct3, addr, wdata; go to ACC1.
REQ-021 Illegal = both or neither of req_load/req_store, load funct3 in {011,110,111}, or store funct3 > 010; illegal accepted request goes IDLE->RESP, no memory enables ever asserted.
REQ-022 off = addr[1:0]; size = 1/2/4 bytes; split = (off + size > 4).
REQ-023 ACC1: mem_addr = word index of addr; ACC2: word index + 1, modulo 2^30 (0x3FFFFFFF wraps to 0).
REQ-024 ACC1 -> ACC2 if split, else -> RESP; ACC2 -> RESP; RESP -> IDLE.
REQ-025 Store mask ACC1 = (size ones << off) truncated to 4 bits; ACC2 = (size ones) >> (4 - off).
REQ-026 Store data ACC1 = wdata << 8*off; ACC2 = wdata >> 8*(4 - off); upper bytes for SB/SH don't-care but lanes outside mask ignored.
REQ-027 Memory commits on the following negedge; unit holds addr/mask/wdata/enables stable for the whole ACC cycle.
REQ-028 Load: mem_rdata sampled at posedge ending ACC1 (word0) and ACC2 (word1, else 0); result = ({word1, word0} >> 8*off)[31:0].
REQ-029 LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unmodified.
REQ-030 In all non-ACC states mem_rd_en, mem_wr_en, mem_mask = 0; mem_addr, mem_wdata hold last value.
REQ-031 RESP: rsp_valid = 1 for exactly one cycle; rsp_err, rsp_data registered, stable only while rsp_valid.
REQ-032 Latency from accept: aligned 3 cycles to rsp_valid, split 4, illegal 2; next request accepted the cycle after RESP.
REQ-033 Requests offered outside IDLE are ignored (not queued); upstream holds them.

Reset
REQ-034 rst in any state: next state IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, enables=0, mask=0, mem_addr=0, mem_wdata=0, req_ready=1 the cycle after reset.
REQ-035 rst during ACC1/ACC2 aborts the transaction: no rsp_valid; a partial split store may have committed ACC1 bytes only; no ACC2 write occurs.

Verification
REQ-036 SW addr 0x10, wdata 0xDEADBEEF -> ACC1 mem_addr=4, mask=1111, wdata=0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_data=0.
REQ-037 LB addr 0x13, mem word 0x80112233 -> rsp_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SW addr 0x0D, wdata 0x11223344 -> ACC1 addr 3 mask 1110 wdata 0x22334400; ACC2 addr 4 mask 0001 wdata 0x00000011; rsp 4 cycles after accept.
REQ-039 LH addr 0x0F, word3=0xAB000000, word4=0x000000CD -> rsp_data=0xFFFFCDAB.
REQ-040 req_funct3=011 load -> no enables, rsp_valid+rsp_err 2 cycles after accept, rsp_data=0; req_load=req_store=1 -> same.
REQ-041 rst asserted in ACC1 of split SW -> no ACC2 write, no rsp_valid, req_ready=1 next cycle.
